hilo_muldiv: RTL and testbench

- Multi-cycle multiply/divide unit with the architectural HI/LO registers. Sits beside the execute-stage ALU and takes the same X/Y operands.
- Replaces the ALU's combinational divide path with a 32-iteration restoring divider.
- Registers all products, quotients and remainders into HI/LO.
- Raises Busy so the pipeline stalls MFHI/MFLO and new mult/div until the result lands.

---
 rtl/muldiv_pkg.sv | 9 +
 rtl/div_step.sv | 13 +
 rtl/hilo_muldiv.sv | 101 ++++++++++
 tb/tb_hilo_muldiv.sv | 128 ++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, FSM states and divide iteration count shared by hilo_muldiv.
package muldiv_pkg;
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;
  localparam int DIV_ITER = 32;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step on a packed {remainder, quotient} pair.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] rq,
  input  logic [WIDTH-1:0]   dvs,
  output logic [2*WIDTH-1:0] rq_n
);
  logic [WIDTH:0] diff;
  // The shifted remainder is WIDTH+1 bits so large unsigned divisors compare correctly
  assign diff = rq[2*WIDTH-1:WIDTH-1] - {1'b0, dvs};
  assign rq_n = diff[WIDTH] ? {rq[2*WIDTH-2:0], 1'b0} : {diff[WIDTH-1:0], rq[WIDTH-2:0], 1'b1};
endmodule

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: multi-cycle multiply/restoring-divide unit owning the HI/LO registers.
// Define MULDIV_EARLY_OUT_EN to finish divides with |X| < |Y| after a single busy cycle.
module hilo_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH      = DIV_ITER,
  parameter int MUL_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             HiWe,
  input  logic             LoWe,
  input  logic [WIDTH-1:0] WData,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);
  localparam int CW  = $clog2(WIDTH);
  localparam int MCW = MUL_CYCLES > 1 ? $clog2(MUL_CYCLES) : 1;
  state_t state, state_n;
  logic [1:0] op_q;
  logic [WIDTH-1:0] x_q, y_q, dvs, ax, ay, q_fix, r_fix;
  logic [2*WIDTH-1:0] rq, rq_n, ex, ey, prod;
  logic [CW-1:0] cnt;
  logic [MCW-1:0] mcnt;
  logic early, early_in, div_zero, idle_like, go, last_mul, last_div, neg_q, neg_r;
  assign idle_like = state == IDLE || state == DONE;
  assign go        = idle_like && Start;
  assign last_mul  = state == MUL && mcnt == '0;
  assign last_div  = state == DIV && cnt == '0;
  assign ax = (Op == OP_DIV && X[WIDTH-1]) ? -X : X;
  assign ay = (Op == OP_DIV && Y[WIDTH-1]) ? -Y : Y;
`ifdef MULDIV_EARLY_OUT_EN
  assign early_in = ax < ay;
`else
  assign early_in = 1'b0;
`endif
  assign ex   = op_q[0] ? {{WIDTH{1'b0}}, x_q} : {{WIDTH{x_q[WIDTH-1]}}, x_q};
  assign ey   = op_q[0] ? {{WIDTH{1'b0}}, y_q} : {{WIDTH{y_q[WIDTH-1]}}, y_q};
  assign prod = ex * ey;
  div_step #(.WIDTH(WIDTH)) u_step (.rq(rq), .dvs(dvs), .rq_n(rq_n));
  assign neg_q = op_q == OP_DIV && (x_q[WIDTH-1] ^ y_q[WIDTH-1]);
  assign neg_r = op_q == OP_DIV && x_q[WIDTH-1];
  assign q_fix = neg_q ? -rq_n[WIDTH-1:0] : rq_n[WIDTH-1:0];
  assign r_fix = neg_r ? -rq_n[2*WIDTH-1:WIDTH] : rq_n[2*WIDTH-1:WIDTH];
  assign Busy    = state == MUL || state == DIV;
  assign Done    = state == DONE;
  assign DivZero = div_zero;
  always_comb begin
    state_n = state;
    if (go) state_n = !Op[1] ? MUL : (Y == '0 ? DONE : DIV);
    else if (state == DONE) state_n = IDLE;
    else if (last_mul || last_div) state_n = DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      rq       <= '0;
      dvs      <= '0;
      cnt      <= '0;
      mcnt     <= '0;
      early    <= 1'b0;
      div_zero <= 1'b0;
      Hi       <= '0;
      Lo       <= '0;
    end else begin
      if (go) begin
        op_q  <= Op;
        x_q   <= X;
        y_q   <= Y;
        rq    <= {{WIDTH{1'b0}}, ax};
        dvs   <= ay;
        cnt   <= early_in ? '0 : CW'(WIDTH - 1);
        mcnt  <= MCW'(MUL_CYCLES - 1);
        early <= early_in;
      end else if (state == DIV) begin
        rq  <= rq_n;
        cnt <= cnt - CW'(1);
      end else if (state == MUL) mcnt <= mcnt - MCW'(1);
      div_zero <= go && Op[1] && Y == '0;
      if (last_mul) {Hi, Lo} <= prod;
      else if (last_div) begin
        Hi <= early ? x_q : r_fix;
        Lo <= early ? '0 : q_fix;
      end else if (idle_like) begin
        if (HiWe) Hi <= WData;
        if (LoWe) Lo <= WData;
      end
    end
endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: directed self-checking bench for hilo_muldiv.
module tb_hilo_muldiv;
  import muldiv_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, Start = 1'b0, HiWe = 1'b0, LoWe = 1'b0;
  logic [1:0] Op = 2'b00;
  logic [31:0] X = '0, Y = '0, WData = '0, Hi, Lo;
  logic Busy, Done, DivZero;
  int pass_cnt = 0, total_cnt = 0;
  int n;
  hilo_muldiv dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .Op(Op), .X(X), .Y(Y),
    .HiWe(HiWe), .LoWe(LoWe), .WData(WData), .Hi(Hi), .Lo(Lo),
    .Busy(Busy), .Done(Done), .DivZero(DivZero)
  );
  always #5 clk = ~clk;
  task automatic launch(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    Start = 1'b1; Op = op; X = x; Y = y;
    @(posedge clk); #1;
    Start = 1'b0; X = ~x; Y = ~y;
  endtask
  task automatic mt_write(input logic hi_we, input logic lo_we, input logic [31:0] d);
    @(negedge clk);
    HiWe = hi_we; LoWe = lo_we; WData = d;
    @(posedge clk); #1;
    HiWe = 1'b0; LoWe = 1'b0;
  endtask
  task automatic wait_done(input int start_n, output int edges);
    edges = start_n;
    while (!Done && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask
  task automatic test_reset;
    #12;
    total_cnt++; if ({Hi, Lo} !== 64'h0) $display("FAIL reset_hilo got %h exp 0", {Hi, Lo}); else pass_cnt++;
    total_cnt++; if ({Busy, Done, DivZero} !== 3'b000) $display("FAIL reset_flags got %b exp 000", {Busy, Done, DivZero}); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
  endtask
  task automatic test_mult;
    launch(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    total_cnt++; if (Busy !== 1'b1) $display("FAIL mult_busy got %b exp 1", Busy); else pass_cnt++;
    wait_done(1, n);
    total_cnt++; if (n !== 2) $display("FAIL mult_latency got %0d exp 2", n); else pass_cnt++;
    total_cnt++; if ({Hi, Lo} !== 64'hFFFF_FFFF_FFFF_FFFA) $display("FAIL mult_result got %h exp ffffffff_fffffffa", {Hi, Lo}); else pass_cnt++;
    launch(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
    wait_done(1, n);
    total_cnt++; if (n !== 2) $display("FAIL multu_latency got %0d exp 2", n); else pass_cnt++;
    total_cnt++; if ({Hi, Lo} !== 64'h0000_0002_FFFF_FFFA) $display("FAIL multu_result got %h exp 00000002_fffffffa", {Hi, Lo}); else pass_cnt++;
    mt_write(1'b0, 1'b1, 32'h0BAD_F00D);
    total_cnt++; if ({Hi, Lo} !== 64'h0000_0002_0BAD_F00D) $display("FAIL mtlo_idle got %h exp 00000002_0badf00d", {Hi, Lo}); else pass_cnt++;
  endtask
  task automatic test_div;
    launch(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    total_cnt++; if (Busy !== 1'b1) $display("FAIL div_busy got %b exp 1", Busy); else pass_cnt++;
    wait_done(1, n);
    total_cnt++; if (n !== 33) $display("FAIL div_latency got %0d exp 33", n); else pass_cnt++;
    total_cnt++; if ({Hi, Lo} !== 64'hFFFF_FFFF_FFFF_FFFD) $display("FAIL div_result got %h exp ffffffff_fffffffd", {Hi, Lo}); else pass_cnt++;
    launch(OP_DIVU, 32'd100, 32'd7);
    wait_done(1, n);
    total_cnt++; if ({Hi, Lo, n} !== {32'd2, 32'd14, 32'd33}) $display("FAIL divu_result got hi=%0d lo=%0d lat=%0d exp hi=2 lo=14 lat=33", Hi, Lo, n); else pass_cnt++;
  endtask
  task automatic test_divzero;
    mt_write(1'b1, 1'b1, 32'hAAAA_AAAA);
    mt_write(1'b0, 1'b1, 32'h5555_5555);
    launch(OP_DIVU, 32'd5, 32'd0);
    total_cnt++; if ({Done, DivZero, Busy} !== 3'b110) $display("FAIL divzero_flags got %b exp 110", {Done, DivZero, Busy}); else pass_cnt++;
    total_cnt++; if ({Hi, Lo} !== 64'hAAAA_AAAA_5555_5555) $display("FAIL divzero_hilo got %h exp aaaaaaaa_55555555", {Hi, Lo}); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if ({Done, DivZero} !== 2'b00) $display("FAIL divzero_pulse got %b exp 00", {Done, DivZero}); else pass_cnt++;
  endtask
  task automatic test_ignore;
    launch(OP_DIVU, 32'd100, 32'd7);
    repeat (9) begin @(posedge clk); #1; end
    @(negedge clk);
    Start = 1'b1; Op = OP_MULT; X = 32'd3; Y = 32'd3; HiWe = 1'b1; WData = 32'h1234_5678;
    @(posedge clk); #1;
    Start = 1'b0; HiWe = 1'b0;
    total_cnt++; if (Hi !== 32'hAAAA_AAAA) $display("FAIL ignore_hiwe got %h exp aaaaaaaa", Hi); else pass_cnt++;
    wait_done(11, n);
    total_cnt++; if (n !== 33) $display("FAIL ignore_latency got %0d exp 33", n); else pass_cnt++;
    total_cnt++; if ({Hi, Lo} !== {32'd2, 32'd14}) $display("FAIL ignore_result got %h exp 00000002_0000000e", {Hi, Lo}); else pass_cnt++;
  endtask
  task automatic test_overflow;
    launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(1, n);
    total_cnt++; if ({Hi, Lo} !== 64'h0000_0000_8000_0000) $display("FAIL div_overflow got %h exp 00000000_80000000", {Hi, Lo}); else pass_cnt++;
    launch(OP_DIV, 32'd7, 32'hFFFF_FFFE);
    wait_done(1, n);
    total_cnt++; if ({Hi, Lo} !== 64'h0000_0001_FFFF_FFFD) $display("FAIL div_posneg got %h exp 00000001_fffffffd", {Hi, Lo}); else pass_cnt++;
  endtask
  task automatic test_back_to_back;
    launch(OP_DIVU, 32'd100, 32'd7);
    wait_done(1, n);
    launch(OP_MULTU, 32'h0001_0000, 32'h0001_0000);
    total_cnt++; if ({Busy, Done} !== 2'b10) $display("FAIL b2b_accept got %b exp 10", {Busy, Done}); else pass_cnt++;
    wait_done(1, n);
    total_cnt++; if ({Hi, Lo, n} !== {32'd1, 32'd0, 32'd2}) $display("FAIL b2b_result got hi=%h lo=%h lat=%0d exp hi=1 lo=0 lat=2", Hi, Lo, n); else pass_cnt++;
    mt_write(1'b1, 1'b0, 32'hCAFE_0001);
    total_cnt++; if ({Hi, Lo} !== 64'hCAFE_0001_0000_0000) $display("FAIL mthi_done got %h exp cafe0001_00000000", {Hi, Lo}); else pass_cnt++;
  endtask
  task automatic test_reset_mid;
    mt_write(1'b1, 1'b1, 32'h1357_9BDF);
    launch(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    repeat (14) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if ({Busy, Done, DivZero} !== 3'b000) $display("FAIL rstmid_flags got %b exp 000", {Busy, Done, DivZero}); else pass_cnt++;
    total_cnt++; if ({Hi, Lo} !== 64'h0) $display("FAIL rstmid_hilo got %h exp 0", {Hi, Lo}); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    launch(OP_MULTU, 32'd3, 32'd5);
    wait_done(1, n);
    total_cnt++; if ({Hi, Lo, n} !== {32'd0, 32'd15, 32'd2}) $display("FAIL rstmid_restart got hi=%h lo=%h lat=%0d exp hi=0 lo=15 lat=2", Hi, Lo, n); else pass_cnt++;
  endtask
  initial begin
    test_reset;
    test_mult;
    test_div;
    test_divzero;
    test_ignore;
    test_overflow;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
